fsk_frame_sync: RTL and testbench
=================================

// Module: fsk_frame_sync
// PURPOSE
//  Downstream of the FSK demodulator. Takes the recovered serial bit stream plus a one-cycle bit strobe.
//  Hunts for a fixed sync word, then assembles the following frame payload into 16-bit words, MSB first.
//  Presents each word with a one-cycle valid pulse to the parallel sink.
//  Replaces free-running serial-to-parallel capture with frame-aligned capture.
// PARAMETERS
//  DATA_W          16        payload word width (bits)
//  SYNC_W          16        sync word length (bits)
//  SYNC_WORD       16'hEB90  sync pattern, MSB received first
//  WORDS_PER_FRAME 4         payload words following each sync word (1..255)
// PORTS
//  sysclk      in   1       system clock; all logic on rising edge
//  reset       in   1       synchronous, active-high reset
//  enable      in   1       link enable (trans_enable); low = soft abort
//  bit_in      in   1       demodulated bit; sampled only when bit_stb=1
//  bit_stb     in   1       one-sysclk strobe per recovered bit
//  word_out    out  DATA_W  last assembled payload word
//  word_valid  out  1       one-cycle pulse: word_out updated this cycle
//  locked      out  1       high while in DATA/PAR states (frame aligned)
//  frame_cnt   out  8       frames completed, wraps 255->0
//  parity_err  out  1       one-cycle pulse on parity mismatch (FSK_FRAME_PARITY_EN only; else tied 0)
// BEHAVIOUR
//  Reset (reset=1 at a sysclk edge): word_out=0, word_valid=0, locked=0, frame_cnt=0, parity_err=0.
//   Also: state=HUNT, sync shift reg=0, bit/word counters=0.
//  States: HUNT, DATA, PAR (PAR exists only with macro).
//  HUNT: on bit_stb, sreg <= {sreg[SYNC_W-2:0],bit_in}.
//   If the new sreg == SYNC_WORD -> DATA next cycle, bit_cnt=0, word_cnt=0.
//  DATA: on bit_stb, shift bit_in into data shifter and increment bit_cnt.
//   On the DATA_W-th bit, in the same clock edge: word_out <= assembled word; word_valid=1 for exactly that next cycle.
//   Then: next state is PAR if macro on, else word_cnt++ and stay in DATA.
//   Or go to HUNT after the WORDS_PER_FRAME-th word.
//  Frame end: frame_cnt++ (mod 256); sreg cleared so sync bits are not reused; locked drops the cycle HUNT is entered.
//  Latency: word_valid rises 1 sysclk after the strobe carrying the word's LSB.
//  bit_stb=0 cycles: no state or counter change; arbitrary gaps between strobes allowed.
//  bit_stb high on consecutive cycles: each cycle is a distinct bit (full-rate OK).
//  enable=0: next edge -> HUNT, counters and sreg cleared, word_valid=0; word_out and frame_cnt hold.
//   A partial word is discarded.
//  enable=0 and bit_stb=1 on the same cycle: enable wins, bit ignored.
//  Overlapping sync (e.g. payload contains SYNC_WORD): ignored while locked; sync is only searched in HUNT.
//  reset mid-frame: immediate return to reset values on that edge.
// CONFIGURATION
//  FSK_FRAME_PARITY_EN defined:
//   - each payload word is followed by one even-parity bit (XOR of the word ^ bit == 0) and handled in PAR.
//   - The bit is consumed on its strobe; on mismatch parity_err pulses 1 cycle, the same cycle the PAR bit is consumed.
//   - word_valid still fires after the data bits.
//  FSK_FRAME_PARITY_EN undefined: no PAR state; parity_err constant 0; frame = SYNC_W + WORDS_PER_FRAME*DATA_W bits.
// STRUCTURE
//  Package fsk_pkg: state encoding constants (HUNT=2'd0, DATA=2'd1, PAR=2'd2), default SYNC_WORD, DATA_W.
//  Sub-module fsk_sync_shift: SYNC_W shift reg + equality compare.
//   Inputs: sysclk, reset, clr, bit_in, stb. Output: hit (combinational from the post-shift value, registered by FSM).
//  FSM, counters and word assembly stay in this module.
// TESTING
//  1 Reset then send 16'hEB90, then 4 words 16'h1234,16'hABCD,16'h0000,16'hFFFF with stb every 16 clks.
//    -> 4 word_valid pulses in order with those values; frame_cnt=1; locked low after last word.
//  2 Noise 40 random bits containing no EB90 window -> locked stays 0, no word_valid.
//  3 Sync found, 2 words received, enable=0 for 1 cycle.
//    -> HUNT, no 3rd word; word_out=2nd word; resend full frame -> frame_cnt increments normally.
//  4 Back-to-back strobes (bit_stb=1 every cycle) for a full frame -> identical outputs to test 1; each word_valid exactly 1 cycle.
//  5 Payload word 16'hEB90 inside a locked frame -> delivered as data; no re-sync, word count unaffected.
//  6 (macro on) Word 16'h0001 with parity bit 0 -> parity_err pulse; with parity bit 1 -> no pulse; word_valid in both cases.

Source files
------------

// File: rtl/fsk_pkg.sv
// Shared definitions for the FSK frame synchroniser: state encoding and default framing constants.
package fsk_pkg;

  localparam int          FSK_DATA_W    = 16;
  localparam int          FSK_SYNC_W    = 16;
  localparam logic [15:0] FSK_SYNC_WORD = 16'hEB90;

  typedef enum logic [1:0] {
    HUNT = 2'd0,
    DATA = 2'd1,
    PAR  = 2'd2
  } fsk_state_t;

endpackage

// File: rtl/fsk_sync_shift.sv
// Sync-word hunter: serial shift register with equality compare on the post-shift value.
module fsk_sync_shift
  import fsk_pkg::*;
#(
  parameter int                SYNC_W    = FSK_SYNC_W,
  parameter logic [SYNC_W-1:0] SYNC_WORD = SYNC_W'(FSK_SYNC_WORD)
) (
  input  logic sysclk,
  input  logic reset,
  input  logic clr,
  input  logic bit_in,
  input  logic stb,
  output logic hit
);

  logic [SYNC_W-1:0] sreg;
  logic [SYNC_W-1:0] sreg_nxt;

  assign sreg_nxt = {sreg[SYNC_W-2:0], bit_in};
  // Compare the value the register is about to hold, so the FSM can leave HUNT on the same edge.
  assign hit      = stb && (sreg_nxt == SYNC_WORD);

  always_ff @(posedge sysclk) begin
    if (reset || clr) begin
      sreg <= '0;
    end else if (stb) begin
      sreg <= sreg_nxt;
    end
  end

endmodule

// File: rtl/fsk_frame_sync.sv
// Frame-aligned serial-to-parallel capture behind the FSK demodulator.
// Define FSK_FRAME_PARITY_EN to expect an even-parity bit after every payload word.
module fsk_frame_sync
  import fsk_pkg::*;
#(
  parameter int                DATA_W          = FSK_DATA_W,
  parameter int                SYNC_W          = FSK_SYNC_W,
  parameter logic [SYNC_W-1:0] SYNC_WORD       = SYNC_W'(FSK_SYNC_WORD),
  parameter int                WORDS_PER_FRAME = 4
) (
  input  logic              sysclk,
  input  logic              reset,
  input  logic              enable,
  input  logic              bit_in,
  input  logic              bit_stb,
  output logic [DATA_W-1:0] word_out,
  output logic              word_valid,
  output logic              locked,
  output logic [7:0]        frame_cnt,
  output logic              parity_err
);

  localparam int BIT_CW = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  fsk_state_t        state;
  logic [BIT_CW-1:0] bit_cnt;
  logic [7:0]        word_cnt;
  logic [DATA_W-1:0] shreg;
  logic [DATA_W-1:0] word_nxt;
  logic              last_bit;
  logic              last_word;
  logic              sync_stb;
  logic              sync_hit;
  logic              frame_end;

  assign word_nxt  = DATA_W'({shreg, bit_in});
  assign last_bit  = (bit_cnt == BIT_CW'(DATA_W - 1));
  assign last_word = (word_cnt == 8'(WORDS_PER_FRAME - 1));
  assign sync_stb  = enable && bit_stb && (state == HUNT);

`ifdef FSK_FRAME_PARITY_EN
  assign frame_end = enable && bit_stb && (state == PAR) && last_word;
`else
  assign frame_end = enable && bit_stb && (state == DATA) && last_bit && last_word;
`endif

  // Clearing on frame end keeps the sync bits of one frame from seeding the next hunt.
  fsk_sync_shift #(
    .SYNC_W   (SYNC_W),
    .SYNC_WORD(SYNC_WORD)
  ) u_sync (
    .sysclk(sysclk),
    .reset (reset),
    .clr   (!enable || frame_end),
    .bit_in(bit_in),
    .stb   (sync_stb),
    .hit   (sync_hit)
  );

  // Payload shifter carries data only; every bit is overwritten before a word is emitted.
  always_ff @(posedge sysclk) begin
    if (enable && bit_stb && (state == DATA)) begin
      shreg <= word_nxt;
    end
  end

`ifdef FSK_FRAME_PARITY_EN
  logic parity_q;
  assign parity_err = parity_q;
`else
  assign parity_err = 1'b0;
`endif

  always_ff @(posedge sysclk) begin
    if (reset) begin
      state      <= HUNT;
      locked     <= 1'b0;
      word_valid <= 1'b0;
      word_out   <= '0;
      frame_cnt  <= 8'd0;
      bit_cnt    <= '0;
      word_cnt   <= 8'd0;
`ifdef FSK_FRAME_PARITY_EN
      parity_q   <= 1'b0;
`endif
    end else begin
      word_valid <= 1'b0;
`ifdef FSK_FRAME_PARITY_EN
      parity_q   <= 1'b0;
`endif
      if (!enable) begin
        state    <= HUNT;
        locked   <= 1'b0;
        bit_cnt  <= '0;
        word_cnt <= 8'd0;
      end else if (bit_stb) begin
        case (state)
          HUNT: begin
            if (sync_hit) begin
              state    <= DATA;
              locked   <= 1'b1;
              bit_cnt  <= '0;
              word_cnt <= 8'd0;
            end
          end
          DATA: begin
            bit_cnt <= bit_cnt + 1'b1;
            if (last_bit) begin
              word_out   <= word_nxt;
              word_valid <= 1'b1;
              bit_cnt    <= '0;
`ifdef FSK_FRAME_PARITY_EN
              state      <= PAR;
`else
              if (last_word) begin
                state     <= HUNT;
                locked    <= 1'b0;
                word_cnt  <= 8'd0;
                frame_cnt <= frame_cnt + 8'd1;
              end else begin
                word_cnt  <= word_cnt + 8'd1;
              end
`endif
            end
          end
`ifdef FSK_FRAME_PARITY_EN
          PAR: begin
            // word_out already holds the word this parity bit covers.
            parity_q <= (^word_out) ^ bit_in;
            if (last_word) begin
              state     <= HUNT;
              locked    <= 1'b0;
              word_cnt  <= 8'd0;
              frame_cnt <= frame_cnt + 8'd1;
            end else begin
              state     <= DATA;
              word_cnt  <= word_cnt + 8'd1;
            end
          end
`endif
          default: begin
            state  <= HUNT;
            locked <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_fsk_frame_sync.sv
// Scoreboard bench for fsk_frame_sync: expected words queued at stimulus time, popped on word_valid.
module tb_fsk_frame_sync;

`ifdef FSK_FRAME_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  logic        sysclk = 1'b0;
  logic        reset;
  logic        enable;
  logic        bit_in;
  logic        bit_stb;
  logic [15:0] word_out;
  logic        word_valid;
  logic        locked;
  logic [7:0]  frame_cnt;
  logic        parity_err;

  always #5 sysclk = ~sysclk;

  fsk_frame_sync dut (
    .sysclk    (sysclk),
    .reset     (reset),
    .enable    (enable),
    .bit_in    (bit_in),
    .bit_stb   (bit_stb),
    .word_out  (word_out),
    .word_valid(word_valid),
    .locked    (locked),
    .frame_cnt (frame_cnt),
    .parity_err(parity_err)
  );

  int          n_checks = 0;
  int          n_pass   = 0;
  logic [15:0] exp_q[$];
  int          cyc = 0;
  int          last_stb_cyc = -10;
  logic        prev_valid = 1'b0;
  int          perr_cnt = 0;
  logic        locked_seen = 1'b0;
  int          exp_fc = 0;

  logic [15:0] f_basic [4] = '{16'h1234, 16'hABCD, 16'h0000, 16'hFFFF};
  logic [15:0] f_alt   [4] = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
  logic [15:0] f_sync  [4] = '{16'hEB90, 16'h5A5A, 16'hEB90, 16'h0F0F};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
  endtask

  always @(posedge sysclk) begin
    cyc++;
    if (bit_stb) last_stb_cyc = cyc;
  end

  always @(negedge sysclk) begin
    if (word_valid === 1'b1) begin
      check("valid_width", {31'd0, prev_valid}, 0);
      check("valid_latency", cyc - last_stb_cyc, 0);
      if (exp_q.size() == 0) check("unexpected_valid", {31'd0, word_valid}, 0);
      else check("word", {16'd0, word_out}, {16'd0, exp_q.pop_front()});
    end
    prev_valid = word_valid;
    if (parity_err === 1'b1) perr_cnt++;
    if (locked === 1'b1) locked_seen = 1'b1;
  end

  task automatic send_bit(input logic b, input int gap);
    bit_in  = b;
    bit_stb = 1'b1;
    @(negedge sysclk);
    bit_stb = 1'b0;
    repeat (gap - 1) @(negedge sysclk);
  endtask

  task automatic send_word(input logic [15:0] w, input int gap, input logic bad_par);
    for (int i = 15; i >= 0; i--) send_bit(w[i], gap);
    if (PAR_EN) send_bit((^w) ^ bad_par, gap);
  endtask

  task automatic send_sync(input int gap);
    logic [15:0] s;
    s = 16'hEB90;
    for (int i = 15; i >= 0; i--) send_bit(s[i], gap);
    check("locked_after_sync", {31'd0, locked}, 1);
  endtask

  task automatic send_frame(input logic [15:0] w [4], input int gap);
    for (int i = 0; i < 4; i++) exp_q.push_back(w[i]);
    send_sync(gap);
    for (int i = 0; i < 4; i++) send_word(w[i], gap, 1'b0);
    exp_fc++;
    @(negedge sysclk);
    check("locked_after_frame", {31'd0, locked}, 0);
    check("frame_cnt", {24'd0, frame_cnt}, exp_fc);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [39:0] nb;
    logic [55:0] full;
    logic        clean;

    reset = 1'b1; enable = 1'b1; bit_in = 1'b0; bit_stb = 1'b0;
    repeat (3) @(negedge sysclk);
    reset = 1'b0;
    @(negedge sysclk);
    check("rst_word_out", {16'd0, word_out}, 0);
    check("rst_word_valid", {31'd0, word_valid}, 0);
    check("rst_locked", {31'd0, locked}, 0);
    check("rst_frame_cnt", {24'd0, frame_cnt}, 0);
    check("rst_parity_err", {31'd0, parity_err}, 0);

    // Test 1: slow strobes, one frame
    send_frame(f_basic, 16);

    // Test 2: noise with no sync window
    do begin
      nb = 40'({$urandom(), $urandom()});
      full = {16'h0000, nb};
      clean = 1'b1;
      for (int k = 1; k <= 40; k++) if (full[55-k -: 16] == 16'hEB90) clean = 1'b0;
    end while (!clean);
    locked_seen = 1'b0;
    for (int i = 39; i >= 0; i--) send_bit(nb[i], 3);
    repeat (2) @(negedge sysclk);
    check("noise_locked", {31'd0, locked_seen}, 0);
    check("noise_frame_cnt", {24'd0, frame_cnt}, exp_fc);

    // Test 3: abort mid-word, enable low with a coincident strobe
    exp_q.push_back(f_alt[0]);
    exp_q.push_back(f_alt[1]);
    send_sync(2);
    send_word(f_alt[0], 2, 1'b0);
    send_word(f_alt[1], 2, 1'b0);
    for (int i = 15; i >= 8; i--) send_bit(f_basic[1][i], 2);
    enable = 1'b0; bit_in = 1'b1; bit_stb = 1'b1;
    @(negedge sysclk);
    enable = 1'b1; bit_stb = 1'b0;
    check("abort_locked", {31'd0, locked}, 0);
    for (int i = 7; i >= 0; i--) send_bit(f_basic[1][i], 2);
    repeat (2) @(negedge sysclk);
    check("abort_word_out", {16'd0, word_out}, 32'h2222);
    check("abort_frame_cnt", {24'd0, frame_cnt}, exp_fc);
    check("abort_locked_tail", {31'd0, locked}, 0);
    send_frame(f_basic, 2);

    // Test 4: full-rate strobes
    send_frame(f_basic, 1);

    // Test 5: sync pattern inside payload
    send_frame(f_sync, 1);

`ifdef FSK_FRAME_PARITY_EN
    // Test 6: parity error on the first word only
    perr_cnt = 0;
    for (int i = 0; i < 4; i++) exp_q.push_back(16'h0001);
    send_sync(2);
    send_word(16'h0001, 2, 1'b1);
    check("parity_bad", perr_cnt, 1);
    send_word(16'h0001, 2, 1'b0);
    check("parity_good", perr_cnt, 1);
    send_word(16'h0001, 2, 1'b0);
    send_word(16'h0001, 2, 1'b0);
    exp_fc++;
    @(negedge sysclk);
    check("parity_frame_cnt", {24'd0, frame_cnt}, exp_fc);
`endif

    // Test 7: reset in mid-frame, then recover
    send_sync(2);
    for (int i = 15; i >= 8; i--) send_bit(f_alt[2][i], 2);
    reset = 1'b1;
    @(negedge sysclk);
    reset = 1'b0;
    exp_fc = 0;
    check("midrst_word_out", {16'd0, word_out}, 0);
    check("midrst_locked", {31'd0, locked}, 0);
    check("midrst_frame_cnt", {24'd0, frame_cnt}, 0);
    check("midrst_word_valid", {31'd0, word_valid}, 0);
    send_frame(f_alt, 2);

    repeat (4) @(negedge sysclk);
    check("queue_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
